// File: rtl/eth_result_pkg.sv
// Shared constants, slot state encoding and address helpers for the result slot scheduler.
// Pure declarations: no latency, no backpressure.
package eth_result_pkg;

    localparam int NUM_REQ     = 3;
    localparam int NUM_SLOTS   = 5;
    localparam int SLOT_STRIDE = 1550;
    localparam int ADDR_W      = 32;
    localparam int SLOT_IDX_W  = 3;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_WRITING,
        SLOT_READY
    } slot_state_t;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_IDX_W-1:0] idx);
        logic [ADDR_W-1:0] addr;
        addr = ADDR_W'(idx) * ADDR_W'(SLOT_STRIDE);
        return addr;
    endfunction

    // Circular index step over the slot range, used by the completion queue pointers.
    function automatic logic [SLOT_IDX_W-1:0] slot_inc(input logic [SLOT_IDX_W-1:0] idx);
        logic [SLOT_IDX_W-1:0] nxt;
        nxt = (idx == SLOT_IDX_W'(NUM_SLOTS - 1)) ? '0 : idx + 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/result_slot_scheduler_if.sv
// Matcher/host handshake bundle for the result slot scheduler; master = requesters + host, slave = scheduler.
// Wires only: no latency; backpressure is carried by req being held and rd_valid/rd_ack.
interface result_slot_scheduler_if;
    import eth_result_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  grant_addr;
    logic               rd_valid;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_ack;
    logic [CNT_W-1:0]   free_cnt;
    logic               timeout_err;

    modport master (
        output req, done, rd_ack,
        input  grant, grant_addr, rd_valid, rd_addr, free_cnt, timeout_err
    );

    modport slave (
        input  req, done, rd_ack,
        output grant, grant_addr, rd_valid, rd_addr, free_cnt, timeout_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Latency: combinational grant, pointer moves to winner+1 at the next edge; en=0 blocks all grants.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        ptr_d = ptr_q;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_q) + k) % N;
                if (gnt == '0 && req[idx]) begin
                    gnt[idx] = 1'b1;
                    ptr_d    = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/result_slot_scheduler.sv
// Allocates result slots to matchers and queues completed slots for the host; RESULT_SLOT_TIMEOUT_EN adds stuck-writer reclaim.
// Latency: grant 1 cycle after req; done reaches the read queue 2 cycles after the pulse (one push per cycle).
// Backpressure: no free slot holds requests pending; unacked rd_valid holds the queue head.
module result_slot_scheduler
    import eth_result_pkg::*;
`ifdef RESULT_SLOT_TIMEOUT_EN
    #(parameter int TIMEOUT = 4096)
`endif
(
    input  logic                    clk,
    input  logic                    rst,
    result_slot_scheduler_if.slave  bus
);

    slot_state_t              slot_q [NUM_SLOTS];
    slot_state_t              slot_d [NUM_SLOTS];
    logic [NUM_REQ-1:0]       own_q, own_d;
    logic [NUM_REQ-1:0]       pend_q, pend_d;
    logic [SLOT_IDX_W-1:0]    own_slot_q [NUM_REQ];
    logic [SLOT_IDX_W-1:0]    own_slot_d [NUM_REQ];
    logic [SLOT_IDX_W-1:0]    cq_q [NUM_SLOTS];
    logic [SLOT_IDX_W-1:0]    cq_d [NUM_SLOTS];
    logic [SLOT_IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]        grant_addr_q, grant_addr_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]         free_cnt_q, free_cnt_d;

    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       arb_gnt;
    logic [SLOT_IDX_W-1:0]    free_idx;
    logic                     pop;
    logic                     push;

`ifdef RESULT_SLOT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]         tmo_q [NUM_REQ];
    logic [TMO_W-1:0]         tmo_d [NUM_REQ];
    logic                     timeout_err_q, timeout_err_d;
`endif

    // A requester keeps ownership until its completion is pushed, so pending done blocks re-arbitration.
    assign eligible = bus.req & ~own_q & ~grant_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (eligible),
        .en  (free_cnt_q != '0),
        .gnt (arb_gnt)
    );

    always_comb begin
        free_idx = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (slot_q[s] == SLOT_FREE) begin
                free_idx = SLOT_IDX_W'(s);
            end
        end
    end

    always_comb begin
        slot_d       = slot_q;
        own_d        = own_q;
        pend_d       = pend_q;
        own_slot_d   = own_slot_q;
        cq_d         = cq_q;
        head_d       = head_q;
        tail_d       = tail_q;
        grant_d      = arb_gnt;
        grant_addr_d = '0;
        pop          = bus.rd_ack && (cnt_q != '0);
        push         = 1'b0;
`ifdef RESULT_SLOT_TIMEOUT_EN
        tmo_d         = tmo_q;
        timeout_err_d = 1'b0;
`endif

        if (pop) begin
            slot_d[cq_q[head_q]] = SLOT_FREE;
            head_d               = slot_inc(head_q);
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!push && pend_q[i]) begin
                push                     = 1'b1;
                slot_d[own_slot_q[i]]    = SLOT_READY;
                cq_d[tail_q]             = own_slot_q[i];
                tail_d                   = slot_inc(tail_q);
                own_d[i]                 = 1'b0;
                pend_d[i]                = 1'b0;
            end
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.done[i] && own_q[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
            end
        end

`ifdef RESULT_SLOT_TIMEOUT_EN
        // A done in the expiry cycle wins over reclaim.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own_q[i] && !pend_q[i] && !bus.done[i]) begin
                if (tmo_q[i] == TMO_W'(TIMEOUT - 1)) begin
                    slot_d[own_slot_q[i]] = SLOT_FREE;
                    own_d[i]              = 1'b0;
                    timeout_err_d         = 1'b1;
                end else begin
                    tmo_d[i] = tmo_q[i] + 1'b1;
                end
            end
        end
`endif

        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                slot_d[free_idx] = SLOT_WRITING;
                own_d[i]         = 1'b1;
                own_slot_d[i]    = free_idx;
                grant_addr_d     = slot_base(free_idx);
`ifdef RESULT_SLOT_TIMEOUT_EN
                tmo_d[i]         = '0;
`endif
            end
        end

        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        free_cnt_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_d[s] == SLOT_FREE) begin
                free_cnt_d = free_cnt_d + 1'b1;
            end
        end

        rd_valid_d = (cnt_d != '0);
        rd_addr_d  = (cnt_d != '0) ? slot_base(cq_d[head_d]) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= SLOT_FREE;
                cq_q[s]   <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                own_slot_q[i] <= '0;
            end
            own_q        <= '0;
            pend_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            grant_addr_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            free_cnt_q   <= CNT_W'(NUM_SLOTS);
        end else begin
            slot_q       <= slot_d;
            cq_q         <= cq_d;
            own_slot_q   <= own_slot_d;
            own_q        <= own_d;
            pend_q       <= pend_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            grant_addr_q <= grant_addr_d;
            rd_valid_q   <= rd_valid_d;
            rd_addr_q    <= rd_addr_d;
            free_cnt_q   <= free_cnt_d;
        end
    end

`ifdef RESULT_SLOT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                tmo_q[i] <= '0;
            end
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant      = grant_q;
    assign bus.grant_addr = grant_addr_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.free_cnt   = free_cnt_q;

endmodule

// File: tb/tb_result_slot_scheduler.sv
// Randomized bench for result_slot_scheduler: a queue-based slot/ownership model predicts every cycle's outputs.
// Expected responses are queued by the stimulus process and popped by an independent monitor.
module tb_result_slot_scheduler;
    import eth_result_pkg::*;

    localparam int STRIDE = 1550;
    localparam int CYCLES = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_slot_scheduler_if bus();

    result_slot_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  grant;
        logic [31:0] grant_addr;
        logic        rd_valid;
        logic [31:0] rd_addr;
        logic [2:0]  free_cnt;
        logic        timeout_err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 0 = free, 1 = writing, 2 = ready
    int m_state[5];
    bit m_own[3];
    int m_slot[3];
    bit m_pend[3];
    bit m_want[3];
    int m_q[$];
    int m_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 5; s++) m_state[s] = 0;
        for (int i = 0; i < 3; i++) begin
            m_own[i]  = 1'b0;
            m_pend[i] = 1'b0;
            m_slot[i] = 0;
        end
        m_q.delete();
        m_rr = 0;
    endtask

    task automatic model_step(input bit r, input logic [2:0] req, input logic [2:0] done,
                              input bit ack, output exp_t e);
        int pf, lf, win, nfree;
        bit pushed;
        bit [2:0] newpend;
        e = '0;
        if (r) begin
            model_reset();
            e.free_cnt = 3'd5;
            return;
        end
        pf = 0;
        lf = -1;
        for (int s = 0; s < 5; s++) begin
            if (m_state[s] == 0) begin
                pf++;
                if (lf < 0) lf = s;
            end
        end
        win = -1;
        if (pf > 0) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_rr + k) % 3;
                if (win < 0 && req[i] && !m_own[i]) win = i;
            end
        end
        for (int i = 0; i < 3; i++) newpend[i] = done[i] && m_own[i] && !m_pend[i];
        if (ack && m_q.size() > 0) begin
            int s;
            s = m_q.pop_front();
            m_state[s] = 0;
        end
        pushed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!pushed && m_pend[i]) begin
                pushed = 1'b1;
                m_q.push_back(m_slot[i]);
                m_state[m_slot[i]] = 2;
                m_own[i]  = 1'b0;
                m_pend[i] = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) if (newpend[i]) m_pend[i] = 1'b1;
        if (win >= 0) begin
            m_state[lf] = 1;
            m_own[win]  = 1'b1;
            m_slot[win] = lf;
            m_rr        = (win + 1) % 3;
            e.grant      = 3'(1 << win);
            e.grant_addr = 32'(lf * STRIDE);
        end
        e.rd_valid = (m_q.size() > 0);
        e.rd_addr  = (m_q.size() > 0) ? 32'(m_q[0] * STRIDE) : 32'd0;
        nfree = 0;
        for (int s = 0; s < 5; s++) if (m_state[s] == 0) nfree++;
        e.free_cnt = 3'(nfree);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation, 1 time unit after each edge.
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                check("grant",       32'(bus.grant),       32'(m.grant));
                check("grant_addr",  bus.grant_addr,       m.grant_addr);
                check("rd_valid",    32'(bus.rd_valid),    32'(m.rd_valid));
                check("rd_addr",     bus.rd_addr,          m.rd_addr);
                check("free_cnt",    32'(bus.free_cnt),    32'(m.free_cnt));
                check("timeout_err", 32'(bus.timeout_err), 32'(m.timeout_err));
            end
        end
    end

    initial begin
        exp_t e;
        bit r, ak;
        logic [2:0] rq, dn;
        int ackp;
        rst        = 1'b1;
        bus.req    = '0;
        bus.done   = '0;
        bus.rd_ack = 1'b0;
        for (int i = 0; i < 3; i++) m_want[i] = 1'b0;
        model_reset();
        e = '0;
        e.free_cnt = 3'd5;
        exp_q.push_back(e);
        @(negedge clk);
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            // Alternate fast-drain and slow-drain phases so the slots both empty out and saturate.
            ackp = ((cyc % 1000) < 500) ? 2 : 12;
            r = (cyc >= 10) && ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!m_want[i] && $urandom_range(0, 3) == 0) m_want[i] = 1'b1;
                rq[i] = m_want[i];
                if (m_own[i] && !m_pend[i]) dn[i] = ($urandom_range(0, 3) == 0);
                else                         dn[i] = ($urandom_range(0, 15) == 0);
            end
            if (m_q.size() > 0) ak = ($urandom_range(0, ackp - 1) == 0);
            else                ak = ($urandom_range(0, 7) == 0);
            rst        = r;
            bus.req    = rq;
            bus.done   = dn;
            bus.rd_ack = ak;
            model_step(r, rq, dn, ak, e);
            for (int i = 0; i < 3; i++) if (e.grant[i]) m_want[i] = 1'b0;
            exp_q.push_back(e);
            @(negedge clk);
        end
        rst        = 1'b0;
        bus.req    = '0;
        bus.done   = '0;
        bus.rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_slot_scheduler.md
Name: result_slot_scheduler

Overview:
- Shares the five result-buffer slots in the output FIFO memory between the packet matchers (URL, IP, port) and hands completed slots to the host read side in completion order.
- Slot k base address = k*1550: 0x0000, 0x060E, 0x0C1C, 0x122A, 0x1838.
- Replaces blind address rotation with allocate / complete / drain tracking.
- Sits between the matcher write engines and the host-side result reader.

Parameters:
NUM_REQ, 3, number of matcher requesters
NUM_SLOTS, 5, number of result slots
SLOT_STRIDE, 1550, bytes per slot; slot base = index*SLOT_STRIDE
ADDR_W, 32, address width
TIMEOUT, 4096, max cycles a slot may stay WRITING (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester slot request, level, held until granted
done  in  NUM_REQ  per-requester 1-cycle pulse: owned slot fully written
grant  out  NUM_REQ  one-hot 1-cycle grant pulse
grant_addr  out  ADDR_W  base address of granted slot, valid with grant
rd_valid  out  1  a completed slot is ready for the host
rd_addr  out  ADDR_W  base address of oldest completed slot
rd_ack  in  1  host consumed slot; honoured only when rd_valid=1
free_cnt  out  3  number of FREE slots
timeout_err  out  1  1-cycle pulse on forced reclaim (0 when feature off)

Behaviour:
- Reset (rst=1 at posedge, synchronous):
  - All slots FREE; completion queue empty; round-robin pointer = 0; no requester owns a slot.
  - Outputs: grant=0, grant_addr=0, rd_valid=0, rd_addr=0, free_cnt=NUM_SLOTS, timeout_err=0.
  - Reset mid-operation discards all ownership and queued results with no pulses.
- Slot states (per slot): FREE -> WRITING (on grant) -> READY (on done) -> FREE (on rd_ack).
- Arbitration, evaluated every cycle:
  - Eligible = req[i]=1 AND requester i owns no slot AND no grant pulse this cycle for i.
  - If any requester is eligible and free_cnt>0: grant to the first eligible at or after the RR pointer; take the lowest-index FREE slot.
  - Registered: grant[i] and grant_addr appear the cycle after the request is seen (1-cycle latency).
  - RR pointer moves to winner+1 mod NUM_REQ.
  - At most one grant per cycle.
  - free_cnt=0: no grant; requests stay pending, none dropped.
- Completion:
  - done[i] from a requester owning a slot marks its slot READY and pushes the slot index to the completion queue (depth NUM_SLOTS, cannot overflow). Ownership is released.
  - Simultaneous done pulses are latched into a pending-done register and pushed one per cycle, lowest requester index first.
  - done[i] with no owned slot is ignored.
- Drain:
  - rd_valid=1 whenever the queue is non-empty; rd_addr = base of the head slot (registered view of the head).
  - rd_ack while rd_valid=1 pops the head; that slot is FREE on the next edge.
  - A freed slot is grantable one cycle later; there is no same-cycle bypass.
  - rd_ack while rd_valid=0 is ignored.
- Simultaneous events: in one cycle, pop (FREE), push (READY) and grant (WRITING) on different slots are all legal. free_cnt = registered count reflecting all three.
- Arithmetic: base address is computed in ADDR_W bits from the index times SLOT_STRIDE; no wrap. Max address = (NUM_SLOTS-1)*SLOT_STRIDE.

Optional Feature:
- Macro: RESULT_SLOT_TIMEOUT_EN.
- Defined:
  - Each WRITING slot has a cycle counter, cleared on grant.
  - When the counter reaches TIMEOUT, the slot returns to FREE (not queued) and the owner loses ownership.
  - timeout_err pulses for 1 cycle. A later done from that requester is ignored.
- Undefined: no counters; slots stay WRITING indefinitely; timeout_err tied 0.

Decomposition:
- Package eth_result_pkg holds:
  - slot_state_t enum {SLOT_FREE, SLOT_WRITING, SLOT_READY};
  - SLOT_STRIDE and NUM_SLOTS constants;
  - slot_base(index) function returning ADDR_W bits.
- Sub-module: rr_arbiter (NUM_REQ-wide round-robin, one-hot grant, pointer update on grant). The completion queue stays inline as a small circular buffer.

Test Plan:
- After reset, req=3'b001 -> next cycle grant=3'b001, grant_addr=0x0000, free_cnt=4.
- req=3'b111 held, no done -> grants to 0,1,2 on consecutive cycles; addrs 0x0000, 0x060E, 0x0C1C; free_cnt=2.
- Requesters 0..2 hold slots 0..2, then done=3'b101 in the same cycle -> queue order slot0 then slot2. rd_valid=1, rd_addr=0x0000; rd_ack -> rd_addr=0x0C1C.
- Fill all 5 slots (requesters re-requesting after done) -> free_cnt=0; req stays pending, no grant. One rd_ack -> that slot regranted 2 cycles later with its address (e.g. 0x0000).
- rst asserted with 3 READY and 2 WRITING slots -> next cycle rd_valid=0, free_cnt=5, grant=0; a late done is ignored.
- RESULT_SLOT_TIMEOUT_EN defined, TIMEOUT=16, grant with no done -> timeout_err pulse 16 cycles after grant, free_cnt restored, no rd_valid.
